// File: rtl/si_mac_acc.sv
// si_mac_acc: accumulates N_INPUTS signed products plus bias, saturates to DATA_W bits, valid/ready on both sides.
// Optional build macro SI_MAC_ACC_RELU_EN clamps negative saturated results to zero.
module si_mac_acc #(
    parameter int DATA_W   = 8,
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] product,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        count
);
    typedef enum logic {ACCUM, OUTPUT} state_t;
    state_t state, state_n;
    logic [ACC_W-1:0] acc, acc_n, acc_add;
    logic [7:0] count_n;
    logic [DATA_W-1:0] y_n, sat, res;
    logic out_valid_n, accept, last, fits;
    logic [ACC_W:0] sum;
    logic [ACC_W-DATA_W+1:0] hi;
    assign in_ready = rst_n && !clear && state == ACCUM;
    assign accept   = in_valid && in_ready;
    assign last     = count == 8'(N_INPUTS - 1);
    assign acc_add  = acc + {{(ACC_W-DATA_W){product[DATA_W-1]}}, product};
    // One extra bit keeps the final bias addition exact before saturation.
    assign sum = {acc[ACC_W-1], acc}
               + {{(ACC_W+1-DATA_W){product[DATA_W-1]}}, product}
               + {{(ACC_W+1-DATA_W){bias[DATA_W-1]}}, bias};
    assign hi   = sum[ACC_W:DATA_W-1];
    assign fits = (&hi) | ~(|hi);
    assign sat  = fits ? sum[DATA_W-1:0] : {sum[ACC_W], {(DATA_W-1){~sum[ACC_W]}}};
`ifdef SI_MAC_ACC_RELU_EN
    assign res = sat[DATA_W-1] ? '0 : sat;
`else
    assign res = sat;
`endif
    always_comb begin
        state_n     = state;
        acc_n       = acc;
        count_n     = count;
        y_n         = y;
        out_valid_n = out_valid;
        if (clear) begin
            state_n     = ACCUM;
            acc_n       = '0;
            count_n     = '0;
            out_valid_n = 1'b0;
        end else if (state == OUTPUT) begin
            if (out_ready) begin
                out_valid_n = 1'b0;
                state_n     = ACCUM;
            end
        end else if (accept) begin
            if (last) begin
                y_n         = res;
                out_valid_n = 1'b1;
                state_n     = OUTPUT;
                acc_n       = '0;
                count_n     = '0;
            end else begin
                acc_n   = acc_add;
                count_n = count + 8'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            count     <= count_n;
            y         <= y_n;
            out_valid <= out_valid_n;
        end
    end
endmodule

// File: tb/tb_si_mac_acc.sv
// tb_si_mac_acc: scoreboard bench; driver queues expected results, a negedge monitor checks each output transfer.
module tb_si_mac_acc;
    localparam int N = 4;
    logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 1, rand_or = 0;
    logic [7:0] product = 0, bias = 0;
    logic in_ready, out_valid;
    logic [7:0] y, count;
    logic [7:0] expq[$];
    int errors = 0, checks = 0, cnt_m = 0;
    logic [7:0] last_y;

    si_mac_acc #(.DATA_W(8), .N_INPUTS(N), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .product(product), .in_valid(in_valid),
        .in_ready(in_ready), .bias(bias), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input int p[N], input int b);
        int s = b;
        foreach (p[i]) s += p[i];
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef SI_MAC_ACC_RELU_EN
        if (s < 0) s = 0;
`endif
        return 8'(s);
    endfunction

    // Monitor: every completed output transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", y);
            end else begin
                last_y = expq.pop_front();
                if (y !== last_y) begin
                    errors++;
                    $display("FAIL output: got %0h expected %0h", y, last_y);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_or) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Entered and left at posedge+1.
    task automatic beat(input int p, input int b);
        int t = 0;
        product = 8'(p);
        bias = 8'(b);
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t == 200) begin
            errors++;
            checks++;
            $display("FAIL beat_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        cnt_m = (cnt_m + 1) % N;
        check("count", count, cnt_m);
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_vec(input int p[N], input int b, input int gap, input bit rnd_gap);
        expq.push_back(model(p, b));
        for (int i = 0; i < N; i++) begin
            idle(rnd_gap ? $urandom_range(0, 2) : gap);
            beat(p[i], b);
        end
    endtask

    initial begin
        int v[N];
        logic [7:0] e;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_count", count, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // Basic vector, back-to-back, out_valid exactly one cycle.
        v = '{15, 8, -13, -8};
        send_vec(v, 0, 0, 0);
        check("basic_valid", out_valid, 1);
        check("basic_y", y, 8'h02);
        @(posedge clk);
        #1;
        check("basic_valid_drop", out_valid, 0);

        v = '{127, 127, 127, 127};
        send_vec(v, 10, 0, 0);
        v = '{-128, -128, -128, -128};
        send_vec(v, -1, 0, 0);
        v = '{-4, -2, -3, -1};
        send_vec(v, 0, 0, 0);
        idle(2);

        // Backpressure: result held, input stalled while out_ready low.
        v = '{3, -7, 20, 1};
        e = model(v, -5);
        out_ready = 0;
        send_vec(v, -5, 0, 0);
        in_valid = 1;
        product = 8'd99;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_y", y, e);
            check("bp_in_ready", in_ready, 0);
        end
        check("bp_count", count, 0);
        @(posedge clk);
        #1;
        in_valid = 0;
        out_ready = 1;
        v = '{1, 1, 1, 1};
        send_vec(v, 2, 0, 0);
        idle(1);

        // in_valid toggling between beats.
        v = '{15, 8, -13, -8};
        send_vec(v, 0, 1, 0);
        idle(1);
        last_y = y;

        // Clear mid-vector discards a simultaneous beat.
        beat(5, 0);
        beat(5, 0);
        clear = 1;
        in_valid = 1;
        product = 8'd9;
        @(negedge clk);
        check("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clear = 0;
        in_valid = 0;
        cnt_m = 0;
        check("clr_count", count, 0);
        check("clr_valid", out_valid, 0);
        check("clr_y_hold", y, 8'h02);
        v = '{1, 1, 1, 1};
        send_vec(v, 2, 0, 0);
        idle(1);

        // Asynchronous reset mid-vector.
        beat(5, 0);
        beat(5, 0);
        #2;
        rst_n = 0;
        #1;
        check("arst_y", y, 0);
        check("arst_valid", out_valid, 0);
        check("arst_count", count, 0);
        check("arst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        cnt_m = 0;
        v = '{1, 1, 1, 1};
        send_vec(v, 2, 0, 0);
        idle(1);

        // Random vectors with random gaps and output stalls.
        rand_or = 1;
        repeat (30) begin
            foreach (v[i]) v[i] = int'($urandom_range(0, 255)) - 128;
            send_vec(v, int'($urandom_range(0, 255)) - 128, 0, 1);
        end
        rand_or = 0;
        @(posedge clk);
        #1;
        out_ready = 1;
        for (int t = 0; t < 50 && expq.size() != 0; t++) idle(1);
        check("drain", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
